dma_master_mc: RTL and testbench

Multi-channel, software-programmable DMA master peripheral for the openMSP430-based Sancus core. The CPU programs per-channel address/data/length/control registers over the 16-bit peripheral bus. The block then issues single or burst word/byte reads and writes on the core's DMA master port, with round-robin arbitration between channels. A `dma_ready` history shift register is kept so that test software can observe DMA stall and interleave behaviour cycle by cycle.

---
 rtl/dma_master_mc.sv | 240 ++++++++++++++++++++++++
 tb/tb_dma_master_mc.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_master_mc.sv
// Multi-channel DMA master: per-channel programmable transfers over the peripheral
// bus, round-robin arbitration onto the core DMA port, and a dma_ready history trace.
module dma_master_mc #(
    parameter logic [14:0] BASE_ADDR = 15'h00A0,
    parameter int          DEC_WD    = 5,
    parameter int          NCH       = 2,
    parameter int          TRACE_WD  = 16
) (
    input  logic                mclk,
    input  logic                puc_rst,
    input  logic [13:0]         per_addr,
    input  logic [15:0]         per_din,
    input  logic                per_en,
    input  logic [1:0]          per_we,
    output logic [15:0]         per_dout,
    output logic [14:0]         dma_addr,
    output logic [15:0]         dma_din,
    output logic                dma_en,
    output logic [1:0]          dma_we,
    output logic                dma_priority,
    output logic                dma_wkup,
    input  logic [15:0]         dma_dout,
    input  logic                dma_ready,
    input  logic                dma_resp,
    output logic                irq,
    output logic [TRACE_WD-1:0] trace
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int OW = DEC_WD - 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RDATA} state_t;

    state_t          r_state, w_state_next;
    logic [CW-1:0]   r_gnt, w_gnt_next;
    logic            r_trace_en;
    logic [TRACE_WD-1:0] r_trace;

    logic [15:0]     w_ch_addr [NCH];
    logic [15:0]     w_ch_data [NCH];
    logic [7:0]      w_ch_len  [NCH];
    logic [NCH-1:0]  w_ch_dir, w_ch_byte, w_ch_inc, w_ch_prio, w_ch_ie;
    logic [NCH-1:0]  w_ch_busy, w_ch_done, w_ch_err;
    logic [NCH-1:0]  w_gnt_oh, w_busy_after;

    logic            w_sel, w_wr, w_rd, w_wr_tctl;
    logic [OW-1:0]   w_woff;
    logic            w_g_dir, w_g_byte;
    logic            w_accept, w_err_ev, w_upd, w_fin;
    logic [CW-1:0]   w_rearb_gnt;

    // First set bit of mask strictly after 'last', wrapping; 'last' itself is lowest priority.
    function automatic logic [CW-1:0] rr_pick(input logic [NCH-1:0] mask, input logic [CW-1:0] last);
        logic [CW-1:0] pick;
        int idx;
        pick = last;
        for (int k = NCH; k >= 1; k--) begin
            idx = (int'(last) + k) % NCH;
            if (mask[idx]) pick = CW'(idx);
        end
        return pick;
    endfunction

    assign w_sel  = per_en & (per_addr[13:OW] == BASE_ADDR[14:DEC_WD]);
    assign w_woff = per_addr[OW-1:0];
    assign w_wr   = w_sel & (per_we != 2'b00);
    assign w_rd   = w_sel & (per_we == 2'b00);
    assign w_wr_tctl = w_wr & per_we[0] & (int'(w_woff) == 4*NCH + 1);

    assign w_g_dir  = w_ch_dir[r_gnt];
    assign w_g_byte = w_ch_byte[r_gnt];

    assign w_accept = (r_state == S_REQ) & dma_ready;
    assign w_err_ev = w_accept & dma_resp;
    assign w_upd    = (w_accept & ~dma_resp & ~w_g_dir) | (r_state == S_RDATA);
    assign w_fin    = w_err_ev | (w_upd & (w_ch_len[r_gnt] == 8'd0));

    assign w_busy_after = w_ch_busy & ~(w_fin ? w_gnt_oh : '0);
    assign w_rearb_gnt  = rr_pick(w_busy_after, r_gnt);

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [15:0] r_addr_c, r_data_c;
        logic [7:0]  r_len_c;
        logic        r_dir_c, r_byte_c, r_inc_c, r_prio_c, r_ie_c;
        logic        r_busy_c, r_done_c, r_err_c;
        logic        w_wr_a, w_wr_d, w_wr_l, w_wr_c, w_upd_c, w_err_c;

        assign w_gnt_oh[gi] = (r_gnt == CW'(gi));
        assign w_wr_a  = w_wr & (int'(w_woff) == 4*gi);
        assign w_wr_d  = w_wr & (int'(w_woff) == 4*gi + 1);
        assign w_wr_l  = w_wr & (int'(w_woff) == 4*gi + 2);
        assign w_wr_c  = w_wr & (int'(w_woff) == 4*gi + 3);
        assign w_upd_c = w_upd & w_gnt_oh[gi];
        assign w_err_c = w_err_ev & w_gnt_oh[gi];

        always_ff @(posedge mclk or posedge puc_rst) begin
            if (puc_rst) begin
                r_addr_c <= '0;
                r_data_c <= '0;
                r_len_c  <= '0;
                r_dir_c  <= 1'b0;
                r_byte_c <= 1'b0;
                r_inc_c  <= 1'b0;
                r_prio_c <= 1'b0;
                r_ie_c   <= 1'b0;
                r_busy_c <= 1'b0;
                r_done_c <= 1'b0;
                r_err_c  <= 1'b0;
            end else begin
                if (!r_busy_c) begin
                    if (w_wr_a && per_we[0]) r_addr_c[7:0]  <= per_din[7:0];
                    if (w_wr_a && per_we[1]) r_addr_c[15:8] <= per_din[15:8];
                    if (w_wr_d && per_we[0]) r_data_c[7:0]  <= per_din[7:0];
                    if (w_wr_d && per_we[1]) r_data_c[15:8] <= per_din[15:8];
                    if (w_wr_l && per_we[0]) r_len_c        <= per_din[7:0];
                    if (w_wr_c && per_we[0]) begin
                        r_dir_c  <= per_din[1];
                        r_byte_c <= per_din[2];
                        r_inc_c  <= per_din[3];
                        r_prio_c <= per_din[4];
                        r_ie_c   <= per_din[5];
                    end
                end
                if (w_wr_c && per_we[1]) begin
                    if (per_din[9])  r_done_c <= 1'b0;
                    if (per_din[10]) r_err_c  <= 1'b0;
                end
                if (w_wr_c && per_we[0] && per_din[0] && !r_busy_c) begin
                    r_busy_c <= 1'b1;
                    r_done_c <= 1'b0;
                    r_err_c  <= 1'b0;
                end
                // Hardware updates come last so a same-cycle W1C cannot hide a completion.
                if (w_upd_c) begin
                    if (r_state == S_RDATA) r_data_c <= dma_dout;
                    if (r_inc_c) r_addr_c <= r_addr_c + (r_byte_c ? 16'd1 : 16'd2);
                    if (r_len_c == 8'd0) begin
                        r_busy_c <= 1'b0;
                        r_done_c <= 1'b1;
                    end else begin
                        r_len_c <= r_len_c - 8'd1;
                    end
                end
                if (w_err_c) begin
                    r_err_c  <= 1'b1;
                    r_done_c <= 1'b1;
                    r_busy_c <= 1'b0;
                end
            end
        end

        assign w_ch_addr[gi] = r_addr_c;
        assign w_ch_data[gi] = r_data_c;
        assign w_ch_len[gi]  = r_len_c;
        assign w_ch_dir[gi]  = r_dir_c;
        assign w_ch_byte[gi] = r_byte_c;
        assign w_ch_inc[gi]  = r_inc_c;
        assign w_ch_prio[gi] = r_prio_c;
        assign w_ch_ie[gi]   = r_ie_c;
        assign w_ch_busy[gi] = r_busy_c;
        assign w_ch_done[gi] = r_done_c;
        assign w_ch_err[gi]  = r_err_c;
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_state <= S_IDLE;
            r_gnt   <= CW'(NCH - 1);
        end else begin
            r_state <= w_state_next;
            r_gnt   <= w_gnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        case (r_state)
            S_IDLE: begin
                if (|w_ch_busy) begin
                    w_gnt_next   = rr_pick(w_ch_busy, r_gnt);
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (dma_ready) begin
                    if (dma_resp || !w_g_dir) begin
                        w_state_next = (|w_busy_after) ? S_REQ : S_IDLE;
                        w_gnt_next   = w_rearb_gnt;
                    end else begin
                        w_state_next = S_RDATA;
                    end
                end
            end
            S_RDATA: begin
                w_state_next = (|w_busy_after) ? S_REQ : S_IDLE;
                w_gnt_next   = w_rearb_gnt;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_trace_en <= 1'b0;
            r_trace    <= '0;
        end else begin
            if (w_wr_tctl) r_trace_en <= per_din[0];
            if (w_wr_tctl && per_din[1]) r_trace <= '0;
            else if (r_trace_en)         r_trace <= {r_trace[TRACE_WD-2:0], dma_ready};
        end
    end

    always_comb begin
        per_dout = '0;
        if (w_rd) begin
            for (int c = 0; c < NCH; c++) begin
                if (int'(w_woff) == 4*c)     per_dout = w_ch_addr[c];
                if (int'(w_woff) == 4*c + 1) per_dout = w_ch_data[c];
                if (int'(w_woff) == 4*c + 2) per_dout = {8'h00, w_ch_len[c]};
                if (int'(w_woff) == 4*c + 3)
                    per_dout = {5'b0, w_ch_err[c], w_ch_done[c], w_ch_busy[c], 2'b0,
                                w_ch_ie[c], w_ch_prio[c], w_ch_inc[c], w_ch_byte[c], w_ch_dir[c], 1'b0};
            end
            if (int'(w_woff) == 4*NCH)     per_dout = 16'(r_trace);
            if (int'(w_woff) == 4*NCH + 1) per_dout = {15'b0, r_trace_en};
        end
    end

    assign dma_en       = (r_state == S_REQ);
    assign dma_addr     = w_ch_addr[r_gnt][15:1];
    assign dma_din      = w_g_byte ? {w_ch_data[r_gnt][7:0], w_ch_data[r_gnt][7:0]} : w_ch_data[r_gnt];
    assign dma_we       = (dma_en && !w_g_dir) ?
                          (w_g_byte ? (w_ch_addr[r_gnt][0] ? 2'b10 : 2'b01) : 2'b11) : 2'b00;
    assign dma_priority = (r_state != S_IDLE) & w_ch_prio[r_gnt];
    assign dma_wkup     = |w_ch_busy;
    assign irq          = |(w_ch_ie & (w_ch_done | w_ch_err));
    assign trace        = r_trace;

endmodule

// File: tb/tb_dma_master_mc.sv
// Directed bench for dma_master_mc: expected DMA transactions are queued when a channel
// is programmed and compared by a monitor whenever the DUT holds a request.
module tb_dma_master_mc;
    localparam int NCH = 2;

    logic        mclk = 1'b0;
    logic        puc_rst = 1'b1;
    logic [13:0] per_addr = '0;
    logic [15:0] per_din = '0;
    logic        per_en = 1'b0;
    logic [1:0]  per_we = 2'b00;
    logic [15:0] per_dout;
    logic [14:0] dma_addr;
    logic [15:0] dma_din;
    logic        dma_en;
    logic [1:0]  dma_we;
    logic        dma_priority;
    logic        dma_wkup;
    logic [15:0] dma_dout = '0;
    logic        dma_ready = 1'b0;
    logic        dma_resp = 1'b0;
    logic        irq;
    logic [15:0] trace;

    dma_master_mc #(.BASE_ADDR(15'h00A0), .DEC_WD(5), .NCH(NCH), .TRACE_WD(16)) dut (
        .mclk(mclk), .puc_rst(puc_rst),
        .per_addr(per_addr), .per_din(per_din), .per_en(per_en), .per_we(per_we), .per_dout(per_dout),
        .dma_addr(dma_addr), .dma_din(dma_din), .dma_en(dma_en), .dma_we(dma_we),
        .dma_priority(dma_priority), .dma_wkup(dma_wkup),
        .dma_dout(dma_dout), .dma_ready(dma_ready), .dma_resp(dma_resp),
        .irq(irq), .trace(trace)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic [14:0] addr;
        logic [1:0]  we;
        logic [15:0] din;
    } txn_t;

    txn_t exp_q[$];
    txn_t mon_t;
    int   checks = 0;
    int   failures = 0;
    int   en_cycles = 0;
    int   en_base = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] waddr(input int ch, input int off);
        int b;
        b = 32'h00A0 + 8*ch + off;
        return 14'(b >> 1);
    endfunction

    task automatic wr(input int ch, input int off, input logic [15:0] d, input logic [1:0] we = 2'b11);
        per_addr = waddr(ch, off);
        per_din  = d;
        per_we   = we;
        per_en   = 1'b1;
        @(posedge mclk);
        #1;
        per_en = 1'b0;
        per_we = 2'b00;
    endtask

    task automatic rd_chk(input string tag, input int ch, input int off, input logic [15:0] exp);
        logic [15:0] d;
        per_addr = waddr(ch, off);
        per_we   = 2'b00;
        per_en   = 1'b1;
        @(negedge mclk);
        d = per_dout;
        @(posedge mclk);
        #1;
        per_en = 1'b0;
        check(tag, 32'(d), 32'(exp));
    endtask

    task automatic push(input logic [14:0] a, input logic [1:0] we, input logic [15:0] d);
        txn_t t;
        t.addr = a;
        t.we   = we;
        t.din  = d;
        exp_q.push_back(t);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (dma_wkup && n < 50) begin
            @(posedge mclk);
            #1;
            n++;
        end
        check(tag, 32'(dma_wkup), 32'd0);
    endtask

    // Every held request is compared against the queue head, so stalls also check stability.
    always @(negedge mclk) begin
        if (!puc_rst && dma_en) begin
            en_cycles++;
            if (exp_q.size() == 0) begin
                if (dma_ready) check("txn_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_t = exp_q[0];
                check("dma_addr", 32'(dma_addr), 32'(mon_t.addr));
                check("dma_we", 32'(dma_we), 32'(mon_t.we));
                if (mon_t.we != 2'b00) check("dma_din", 32'(dma_din), 32'(mon_t.din));
                if (dma_ready) begin
                    void'(exp_q.pop_front());
                    $display("TXN addr=%h we=%b din=%h resp=%b", dma_addr, dma_we, dma_din, dma_resp);
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge mclk);
        #1;
        puc_rst = 1'b0;

        // Reset state
        check("rst_dma_en", 32'(dma_en), 32'd0);
        check("rst_dma_we", 32'(dma_we), 32'd0);
        check("rst_dma_addr", 32'(dma_addr), 32'd0);
        check("rst_dma_din", 32'(dma_din), 32'd0);
        check("rst_wkup", 32'(dma_wkup), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_prio", 32'(dma_priority), 32'd0);
        check("rst_trace", 32'(trace), 32'd0);
        rd_chk("rst_ch0_ctrl", 0, 6, 16'h0000);
        rd_chk("rst_ch1_addr", 1, 0, 16'h0000);
        rd_chk("rst_tctl", NCH, 2, 16'h0000);

        // Single word write on ch0
        dma_ready = 1'b1;
        wr(0, 0, 16'h0200);
        wr(0, 2, 16'hA55A);
        wr(0, 4, 16'h0000);
        push(15'h100, 2'b11, 16'hA55A);
        en_base = en_cycles;
        wr(0, 6, 16'h0001);
        check("t1_en_before_req", 32'(dma_en), 32'd0);
        rd_chk("t1_busy", 0, 6, 16'h0100);
        check("t1_en_req", 32'(dma_en), 32'd1);
        check("t1_addr_req", 32'(dma_addr), 32'h100);
        @(posedge mclk);
        #1;
        check("t1_en_one_cycle", 32'(dma_en), 32'd0);
        wait_idle("t1_idle");
        rd_chk("t1_done", 0, 6, 16'h0200);
        check("t1_en_count", 32'(en_cycles - en_base), 32'd1);

        // Byte burst with a 3-cycle stall and trace capture
        dma_ready = 1'b0;
        wr(0, 0, 16'h0301);
        wr(0, 2, 16'h0042);
        wr(0, 4, 16'h0002);
        push(15'h180, 2'b10, 16'h4242);
        push(15'h181, 2'b01, 16'h4242);
        push(15'h181, 2'b10, 16'h4242);
        wr(NCH, 2, 16'h0003);
        wr(0, 6, 16'h000D);
        repeat (4) @(posedge mclk);
        #1;
        dma_ready = 1'b1;
        repeat (3) @(posedge mclk);
        #1;
        wr(NCH, 2, 16'h0000);
        wait_idle("t2_idle");
        rd_chk("t2_addr", 0, 0, 16'h0304);
        rd_chk("t2_len", 0, 4, 16'h0000);
        rd_chk("t2_ctrl", 0, 6, 16'h020C);
        rd_chk("t2_trace", NCH, 0, 16'h000F);

        // Single read on ch1 with interrupt
        dma_dout = 16'hBEEF;
        wr(1, 0, 16'h0400);
        push(15'h200, 2'b00, 16'h0000);
        en_base = en_cycles;
        wr(1, 6, 16'h0023);
        wait_idle("t3_idle");
        check("t3_en_count", 32'(en_cycles - en_base), 32'd1);
        check("t3_irq_set", 32'(irq), 32'd1);
        rd_chk("t3_data", 1, 2, 16'hBEEF);
        rd_chk("t3_ctrl", 1, 6, 16'h0222);
        wr(1, 6, 16'h0200, 2'b10);
        check("t3_irq_clr", 32'(irq), 32'd0);
        rd_chk("t3_ctrl_w1c", 1, 6, 16'h0022);

        // Two-channel round-robin
        dma_ready = 1'b0;
        wr(0, 0, 16'h1000);
        wr(0, 2, 16'h1111);
        wr(0, 4, 16'h0001);
        wr(1, 0, 16'h2000);
        wr(1, 2, 16'h2222);
        wr(1, 4, 16'h0001);
        push(15'h800, 2'b11, 16'h1111);
        push(15'h1000, 2'b11, 16'h2222);
        push(15'h801, 2'b11, 16'h1111);
        push(15'h1001, 2'b11, 16'h2222);
        wr(0, 6, 16'h0009);
        wr(1, 6, 16'h0009);
        en_base = en_cycles;
        dma_ready = 1'b1;
        wait_idle("t4_idle");
        check("t4_en_count", 32'(en_cycles - en_base), 32'd4);
        rd_chk("t4_ch0_addr", 0, 0, 16'h1004);
        rd_chk("t4_ch1_addr", 1, 0, 16'h2004);

        // Error response on the first transfer of a LEN=5 burst
        dma_resp = 1'b1;
        wr(0, 0, 16'h0500);
        wr(0, 2, 16'h5555);
        wr(0, 4, 16'h0005);
        push(15'h280, 2'b11, 16'h5555);
        en_base = en_cycles;
        wr(0, 6, 16'h0009);
        wait_idle("t5_idle");
        repeat (3) @(posedge mclk);
        #1;
        dma_resp = 1'b0;
        check("t5_en_count", 32'(en_cycles - en_base), 32'd1);
        rd_chk("t5_ctrl", 0, 6, 16'h0608);
        rd_chk("t5_len", 0, 4, 16'h0005);
        rd_chk("t5_addr", 0, 0, 16'h0500);

        // Register writes ignored while busy
        dma_ready = 1'b0;
        wr(0, 0, 16'h0600);
        wr(0, 4, 16'h0000);
        push(15'h300, 2'b11, 16'h5555);
        wr(0, 6, 16'h0001);
        wr(0, 0, 16'h0700);
        wr(0, 4, 16'h0007);
        rd_chk("t6_addr_busy", 0, 0, 16'h0600);
        rd_chk("t6_len_busy", 0, 4, 16'h0000);
        dma_ready = 1'b1;
        wait_idle("t6_idle");
        rd_chk("t6_ctrl", 0, 6, 16'h0200);

        // Asynchronous reset mid-request
        dma_ready = 1'b0;
        wr(1, 0, 16'h0800);
        wr(1, 4, 16'h0003);
        wr(1, 6, 16'h0001);
        @(posedge mclk);
        #1;
        check("t7_en_before_rst", 32'(dma_en), 32'd1);
        #1;
        puc_rst = 1'b1;
        #1;
        check("t7_en_async", 32'(dma_en), 32'd0);
        check("t7_wkup_async", 32'(dma_wkup), 32'd0);
        @(posedge mclk);
        #1;
        puc_rst = 1'b0;
        rd_chk("t7_ch1_addr", 1, 0, 16'h0000);
        rd_chk("t7_ch1_ctrl", 1, 6, 16'h0000);
        rd_chk("t7_ch1_data", 1, 2, 16'h0000);
        rd_chk("t7_ch0_ctrl", 0, 6, 16'h0000);
        rd_chk("t7_trace", NCH, 0, 16'h0000);
        check("t7_irq", 32'(irq), 32'd0);
        check("t7_en_after", 32'(dma_en), 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
